sub_serial: RTL and testbench
=============================

# sub_serial

Bit-serial, LSB-first subtractor built around a 1-bit full-subtractor cell. It is the inverse counterpart to the team's 1-bit full-adder datapath. It accepts two DATA_WIDTH operands over a valid/ready handshake and computes a − b one bit per clock. It then presents the result, final borrow and signed overflow over an output valid/ready handshake. It sits in the calc library as the area-cheap alternative to a parallel subtractor.

## Interface
- DATA_WIDTH, 32, operand/result width in bits; legal range ≥ 2
- i_clk  input  1  clock, all logic on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_valid  input  1  operand request valid
- o_ready  output  1  block can accept operands
- i_num_a  input  DATA_WIDTH  minuend
- i_num_b  input  DATA_WIDTH  subtrahend
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_res  output  DATA_WIDTH  a − b, modulo 2^DATA_WIDTH
- o_bor  output  1  final borrow; 1 iff a < b unsigned
- o_ovf  output  1  signed (two's complement) overflow

## Operation
- Reset behaviour:
  - While i_rst_n = 0 at a rising edge, state ← IDLE, o_valid ← 0, o_res ← 0, o_bor ← 0, o_ovf ← 0, and the internal shift registers and counter are cleared.
  - Reset has priority over every other event.
- FSM states: IDLE, CALC, DONE.
- o_ready = (state == IDLE). It is decoded from state only, so it does not depend on i_valid.
- IDLE:
  - On i_valid & o_ready, capture a, b into shift registers, clear borrow and the bit counter, latch a[MSB] and b[MSB], then go to CALC.
  - Otherwise stay in IDLE.
- CALC, once per cycle:
  - Cell inputs: x = a_sh[0], y = b_sh[0], c = borrow.
  - Difference bit: d = x ^ y ^ c.
  - Next borrow: (~x & y) | (~(x ^ y) & c).
  - a_sh and b_sh shift right by one.
  - The result shift register shifts right, with d inserted at the MSB.
  - The counter increments.
  - On the cycle where counter == DATA_WIDTH−1:
    - o_res ← final shifted value.
    - o_bor ← final borrow.
    - o_ovf ← (a_msb ^ b_msb) & (a_msb ^ d).
    - o_valid ← 1; go to DONE.
- DONE:
  - o_valid = 1, and o_res/o_bor/o_ovf are held stable.
  - On i_valid ignored.
  - On i_ready: o_valid ← 0 and go to IDLE. Results remain on o_res/o_bor/o_ovf until the next completion or reset.
- Operands are sampled only at the input handshake. Changes on i_num_a/i_num_b during CALC/DONE have no effect.
- i_valid during CALC or DONE is ignored. The upstream holds the request until o_ready.
- Counter width is $clog2(DATA_WIDTH).

## Timing
- Input handshake at edge E0. CALC occupies edges E1..E_DATA_WIDTH. o_valid rises after edge E_DATA_WIDTH, i.e. exactly DATA_WIDTH cycles after acceptance.
- Output handshake at edge F (o_valid & i_ready): IDLE after F, and o_ready = 1 in the cycle after F.
- Minimum throughput: one operation per DATA_WIDTH+2 cycles. There is no overlap and no same-cycle output/input handshake.
- Reset mid-CALC or mid-DONE aborts the operation:
  - After the reset edge: o_valid = 0, o_res = 0, o_ready = 1.
  - No partial result is ever presented.
- Backpressure: o_valid stays asserted indefinitely while i_ready = 0, with outputs unchanged.

## Test plan
- DATA_WIDTH=8, a=0x05, b=0x03 → o_res=0x02, o_bor=0, o_ovf=0; o_valid first high exactly 8 cycles after the accept edge.
- DATA_WIDTH=8, a=0x03, b=0x05 → o_res=0xFE, o_bor=1, o_ovf=0. Then a=0x80, b=0x01 → o_res=0x7F, o_bor=0, o_ovf=1. Then a=0x7F, b=0xFF → o_res=0x80, o_bor=1, o_ovf=1.
- Backpressure, DATA_WIDTH=8:
  - Stimulus: hold i_ready=0 for 5 cycles in DONE, drive new i_valid with a=0x10, b=0x01 throughout, and change i_num_a mid-CALC.
  - Required: o_res stays at the first result, o_ready=0, and the new request is not taken until the cycle after the output handshake; the second result is 0x0F.
- Reset: assert i_rst_n=0 for one edge on the 3rd CALC cycle → next cycle o_valid=0, o_res=0, o_ready=1; a following a=0x20, b=0x20 gives o_res=0x00, o_bor=0, o_ovf=0.
- Random check, DATA_WIDTH=32, 1000 random operand pairs with random i_valid/i_ready gaps, plus corners 0−0, 0−1, 0x80000000−1 and 0xFFFFFFFF−0xFFFFFFFF:
  - o_res == (a−b) mod 2^32.
  - o_bor == (a<b).
  - o_ovf matches signed overflow.
  - Latency is always 32.

Source files
------------

// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial
//
// Bit-serial, LSB-first subtractor built around a single 1-bit
// full-subtractor cell. Two operands are accepted over a valid/ready
// handshake. The block produces a - b one bit per clock. It then presents
// the difference, the final borrow and the signed overflow flag over an
// output valid/ready handshake.
//
// Ports
//   i_clk    : clock, all logic on the rising edge
//   i_rst_n  : synchronous active-low reset
//   i_valid  : operand request valid
//   o_ready  : block is idle and can accept operands
//   i_num_a  : minuend
//   i_num_b  : subtrahend
//   o_valid  : result valid
//   i_ready  : consumer accepts the result
//   o_res    : a - b modulo 2^DATA_WIDTH
//   o_bor    : final borrow, set when a < b (unsigned)
//   o_ovf    : two's complement overflow of a - b
// ---------------------------------------------------------------------------
module sub_serial #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_bor,
    output logic                  o_ovf
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [DATA_WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [DATA_WIDTH-1:0] res_sh_q, res_sh_d;
    logic                  bor_q,    bor_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic                  a_msb_q,  a_msb_d;
    logic                  b_msb_q,  b_msb_d;
    logic [DATA_WIDTH-1:0] res_q,    res_d;
    logic                  obor_q,   obor_d;
    logic                  oovf_q,   oovf_d;

    // Full-subtractor cell operating on the current LSBs and running borrow.
    logic cell_x, cell_y, cell_c, diff_bit, bor_next;

    assign cell_x   = a_sh_q[0];
    assign cell_y   = b_sh_q[0];
    assign cell_c   = bor_q;
    assign diff_bit = cell_x ^ cell_y ^ cell_c;
    assign bor_next = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_c);

    // Handshake outputs are decoded purely from state, so o_ready never
    // combinationally depends on i_valid.
    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_res   = res_q;
    assign o_bor   = obor_q;
    assign o_ovf   = oovf_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        bor_d    = bor_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        res_d    = res_q;
        obor_d   = obor_q;
        oovf_d   = oovf_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_sh_d  = i_num_a;
                    b_sh_d  = i_num_b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = i_num_a[DATA_WIDTH-1];
                    b_msb_d = i_num_b[DATA_WIDTH-1];
                    state_d = CALC;
                end
            end
            CALC: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // Difference bits enter at the MSB so that after DATA_WIDTH
                // shifts the first (LSB) difference bit sits at bit 0.
                res_sh_d = {diff_bit, res_sh_q[DATA_WIDTH-1:1]};
                bor_d    = bor_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    res_d   = {diff_bit, res_sh_q[DATA_WIDTH-1:1]};
                    obor_d  = bor_next;
                    // Overflow only when operand signs differ and the
                    // result sign differs from the minuend sign.
                    oovf_d  = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_bit);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset clears everything, including the last presented result, so an
    // aborted operation never leaves partial data on the outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            res_q    <= '0;
            obor_q   <= 1'b0;
            oovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            bor_q    <= bor_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            res_q    <= res_d;
            obor_q   <= obor_d;
            oovf_q   <= oovf_d;
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_sub_serial
//
// Self-checking bench for sub_serial. It instantiates an 8-bit and a 32-bit
// copy. The 8-bit copy runs directed cases: basic, backpressure and
// mid-operation reset. The 32-bit copy runs corner cases and random operand
// pairs with random handshake gaps. Expected values come from a plain
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_sub_serial;

    logic clk;
    logic rstN;

    logic        valid8, ready8, oValid8, iReady8, bor8, ovf8;
    logic [7:0]  numA8, numB8, res8;
    logic        valid32, ready32, oValid32, iReady32, bor32, ovf32;
    logic [31:0] numA32, numB32, res32;

    int testsRun;
    int testsFailed;
    bit selWide;

    logic        curReady, curValid, curBor, curOvf;
    logic [31:0] curRes;

    sub_serial #(.DATA_WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_valid (valid8),
        .o_ready (ready8),
        .i_num_a (numA8),
        .i_num_b (numB8),
        .o_valid (oValid8),
        .i_ready (iReady8),
        .o_res   (res8),
        .o_bor   (bor8),
        .o_ovf   (ovf8)
    );

    sub_serial #(.DATA_WIDTH(32)) dut32 (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_valid (valid32),
        .o_ready (ready32),
        .i_num_a (numA32),
        .i_num_b (numB32),
        .o_valid (oValid32),
        .i_ready (iReady32),
        .o_res   (res32),
        .o_bor   (bor32),
        .o_ovf   (ovf32)
    );

    // Route the currently selected instance onto a common set of probes.
    assign curReady = selWide ? ready32  : ready8;
    assign curValid = selWide ? oValid32 : oValid8;
    assign curRes   = selWide ? res32    : {24'h0, res8};
    assign curBor   = selWide ? bor32    : bor8;
    assign curOvf   = selWide ? ovf32    : ovf8;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input longint got, input longint exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain W-bit arithmetic, signed range test for overflow.
    task automatic refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic bor, output logic ovf);
        longint ua, ub, sa, sb, sd, half, full;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua   = longint'(a);
        ub   = longint'(b);
        r    = 32'((ua - ub) & (full - 1));
        bor  = (ua < ub);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        sd   = sa - sb;
        ovf  = (sd >= half) || (sd < -half);
    endtask

    task automatic driveInputs(input bit v, input logic [31:0] a, input logic [31:0] b);
        if (selWide) begin
            valid32 = v; numA32 = a; numB32 = b;
        end else begin
            valid8 = v; numA8 = a[7:0]; numB8 = b[7:0];
        end
    endtask

    task automatic driveReady(input bit r);
        if (selWide) iReady32 = r;
        else         iReady8  = r;
    endtask

    // Waits (bounded) for o_ready, then steps over the accepting edge.
    task automatic waitAccept();
        int waitCnt = 0;
        while (!curReady && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!curReady) checkOutput("acceptTimeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Counts edges from acceptance until o_valid and checks the result.
    task automatic waitDone(input int w, input logic [31:0] r, input logic bor, input logic ovf);
        int lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!curValid && lat < 200);
        checkOutput("latency", longint'(lat), longint'(w));
        checkOutput("res", longint'(curRes), longint'(r));
        checkOutput("bor", longint'(curBor), longint'(bor));
        checkOutput("ovf", longint'(curOvf), longint'(ovf));
    endtask

    // Holds i_ready low for some cycles, then completes the output handshake.
    task automatic holdAndRelease(input int hold, input logic [31:0] r);
        repeat (hold) begin
            @(posedge clk); #1;
            checkOutput("holdValid", longint'(curValid), 1);
            checkOutput("holdReady", longint'(curReady), 0);
            checkOutput("holdRes", longint'(curRes), longint'(r));
        end
        driveReady(1'b1);
        @(posedge clk); #1;
        driveReady(1'b0);
        checkOutput("relValid", longint'(curValid), 0);
        checkOutput("relReady", longint'(curReady), 1);
        checkOutput("relRes", longint'(curRes), longint'(r));
    endtask

    // One complete operation on the selected instance.
    task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b,
                                 input int gap, input int hold);
        int w;
        logic [31:0] er;
        logic eb, eo;
        selWide = wide;
        w = wide ? 32 : 8;
        refModel(w, a, b, er, eb, eo);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        driveInputs(1'b1, a, b);
        waitAccept();
        // Scramble operands after acceptance; they must have no effect.
        driveInputs(1'b0, $urandom, $urandom);
        waitDone(w, er, eb, eo);
        holdAndRelease(hold, er);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        selWide     = 1'b0;
        rstN        = 1'b0;
        valid8 = 1'b0; numA8 = '0; numB8 = '0; iReady8 = 1'b0;
        valid32 = 1'b0; numA32 = '0; numB32 = '0; iReady32 = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReady8", longint'(ready8), 1);
        checkOutput("rstValid8", longint'(oValid8), 0);
        checkOutput("rstRes8", longint'(res8), 0);
        checkOutput("rstBor8", longint'(bor8), 0);
        checkOutput("rstOvf8", longint'(ovf8), 0);
        checkOutput("rstReady32", longint'(ready32), 1);
        checkOutput("rstValid32", longint'(oValid32), 0);
        rstN = 1'b1;

        // Directed 8-bit cases.
        applyStimulus(1'b0, 32'h05, 32'h03, 1, 0);
        applyStimulus(1'b0, 32'h03, 32'h05, 0, 1);
        applyStimulus(1'b0, 32'h80, 32'h01, 2, 0);
        applyStimulus(1'b0, 32'h7F, 32'hFF, 0, 2);

        // Backpressure with a pending second request held throughout.
        selWide = 1'b0;
        driveInputs(1'b1, 32'h33, 32'h11);
        waitAccept();
        driveInputs(1'b1, 32'h77, 32'h01);
        waitDone(8, 32'h22, 1'b0, 1'b0);
        driveInputs(1'b1, 32'h10, 32'h01);
        holdAndRelease(5, 32'h22);
        waitAccept();
        driveInputs(1'b0, 32'h00, 32'h00);
        waitDone(8, 32'h0F, 1'b0, 1'b0);
        holdAndRelease(0, 32'h0F);

        // Reset on the third CALC cycle aborts the operation.
        selWide = 1'b0;
        driveInputs(1'b1, 32'h40, 32'h01);
        waitAccept();
        driveInputs(1'b0, 32'h00, 32'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        checkOutput("abortValid", longint'(oValid8), 0);
        checkOutput("abortRes", longint'(res8), 0);
        checkOutput("abortReady", longint'(ready8), 1);
        applyStimulus(1'b0, 32'h20, 32'h20, 0, 0);

        // 32-bit corners.
        applyStimulus(1'b1, 32'h0, 32'h0, 0, 0);
        applyStimulus(1'b1, 32'h0, 32'h1, 1, 1);
        applyStimulus(1'b1, 32'h80000000, 32'h1, 0, 2);
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0);

        // Random 32-bit operations with random handshake gaps.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
